// File: rtl/mp_limb_adder_if.sv
// Limb-stream bus for mp_limb_adder: operand beats in, result limbs out.
// iSub is present only when MP_LIMB_SUBTRACT_EN is defined.
interface mp_limb_adder_if #(
  parameter int unsigned LIMB_WIDTH = 32
);
  logic                  iValid;
  logic                  oReady;
  logic [LIMB_WIDTH-1:0] iA;
  logic [LIMB_WIDTH-1:0] iB;
  logic                  iFirst;
  logic                  iLast;
  logic                  iC;
`ifdef MP_LIMB_SUBTRACT_EN
  logic                  iSub;
`endif
  logic                  oValid;
  logic                  iReady;
  logic [LIMB_WIDTH-1:0] oSum;
  logic                  oLast;
  logic                  oC;
  logic                  oErr;

  modport master (
    output iValid, iA, iB, iFirst, iLast, iC,
`ifdef MP_LIMB_SUBTRACT_EN
    output iSub,
`endif
    output iReady,
    input  oReady, oValid, oSum, oLast, oC, oErr
  );

  modport slave (
    input  iValid, iA, iB, iFirst, iLast, iC,
`ifdef MP_LIMB_SUBTRACT_EN
    input  iSub,
`endif
    input  iReady,
    output oReady, oValid, oSum, oLast, oC, oErr
  );
endinterface

// File: rtl/mp_limb_adder.sv
// Multi-precision limb adder: 4-bit carry-lookahead groups rippled across the limb,
// limb carry chained through a register. Define MP_LIMB_SUBTRACT_EN to add A-B support.
module mp_limb_adder #(
  parameter int unsigned LIMB_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mp_limb_adder_if.slave bus
);
  localparam int unsigned NumGroups = LIMB_WIDTH / 4;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic                  carry_q;
  logic                  out_valid_q;
  logic [LIMB_WIDTH-1:0] sum_q;
  logic                  oc_q;
  logic                  last_q;
  logic                  err_q;

  logic                  accept;
  logic                  start;
  logic                  err_set;
  logic                  cin;
  logic [LIMB_WIDTH-1:0] b_eff;
  logic [LIMB_WIDTH-1:0] gen;
  logic [LIMB_WIDTH-1:0] prop;
  logic [LIMB_WIDTH-1:0] int_carry;
  logic [LIMB_WIDTH-1:0] sum;
  logic                  cout;

  // Carries into bits 1..4 of a group, fully expanded from the group carry-in.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  assign bus.oReady = ~out_valid_q | bus.iReady;
  assign accept     = bus.iValid & bus.oReady;

  // Framing: a beat starts a new operation in IDLE, or in BUSY when iFirst restarts it.
  always_comb begin
    state_d = state_q;
    start   = 1'b1;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        start = 1'b1;
        if (accept) begin
          err_set = ~bus.iFirst;
          state_d = bus.iLast ? StIdle : StBusy;
        end
      end
      StBusy: begin
        start = bus.iFirst;
        if (accept) begin
          err_set = bus.iFirst;
          state_d = bus.iLast ? StIdle : StBusy;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef MP_LIMB_SUBTRACT_EN
  logic sub_q;
  logic sub_eff;

  assign sub_eff = start ? bus.iSub : sub_q;
  assign b_eff   = sub_eff ? ~bus.iB : bus.iB;
  assign cin     = start ? (bus.iSub | bus.iC) : carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept && start) begin
      sub_q <= bus.iSub;
    end
  end
`else
  assign b_eff = bus.iB;
  assign cin   = start ? bus.iC : carry_q;
`endif

  assign gen  = bus.iA & b_eff;
  assign prop = bus.iA ^ b_eff;

  always_comb begin
    logic       c_run;
    logic [3:0] c4;
    int_carry = '0;
    c4        = '0;
    c_run     = cin;
    for (int k = 0; k < int'(NumGroups); k++) begin
      c4                  = cla4(gen[4*k +: 4], prop[4*k +: 4], c_run);
      int_carry[4*k +: 4] = {c4[2:0], c_run};
      c_run               = c4[3];
    end
    cout = c_run;
  end

  assign sum = prop ^ int_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
    end
  end

  // Output data only moves on accept, so it is frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      oc_q        <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      carry_q     <= bus.iLast ? 1'b0 : cout;
      out_valid_q <= 1'b1;
      sum_q       <= sum;
      oc_q        <= cout;
      last_q      <= bus.iLast;
    end else if (bus.iReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.oValid = out_valid_q;
  assign bus.oSum   = sum_q;
  assign bus.oC     = oc_q;
  assign bus.oLast  = last_q;
  assign bus.oErr   = err_q;
endmodule

// File: tb/tb_mp_limb_adder.sv
// Directed bench for mp_limb_adder (LIMB_WIDTH=32); inputs change and outputs are
// sampled on the falling clock edge.
module tb_mp_limb_adder;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mp_limb_adder_if #(.LIMB_WIDTH(32)) bus ();

  mp_limb_adder #(.LIMB_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic first,
                       input logic last, input logic c);
    bus.iValid = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    bus.iFirst = first;
    bus.iLast  = last;
    bus.iC     = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.iValid = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iFirst = 1'b0;
    bus.iLast  = 1'b0;
    bus.iC     = 1'b0;
    bus.iReady = 1'b1;
`ifdef MP_LIMB_SUBTRACT_EN
    bus.iSub   = 1'b0;
`endif
    #3;
    check("rst_ready", 32'(bus.oReady), 32'd1);
    check("rst_valid", 32'(bus.oValid), 32'd0);
    check("rst_err",   32'(bus.oErr),   32'd0);
    check("rst_sum",   bus.oSum,        32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Single limb with full carry wrap
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    check("single_valid", 32'(bus.oValid), 32'd1);
    check("single_sum",   bus.oSum,        32'h0000_0000);
    check("single_c",     32'(bus.oC),     32'd1);
    check("single_last",  32'(bus.oLast),  32'd1);
    tick();
    check("drain_valid",  32'(bus.oValid), 32'd0);

    // All-ones + 0 + carry-in 1
    drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    check("wrap_sum", bus.oSum,    32'h0);
    check("wrap_c",   32'(bus.oC), 32'd1);
    drive(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b1, 1'b0);
    tick();
    check("add1_sum", bus.oSum,    32'hFFFF_FFFF);
    check("add1_c",   32'(bus.oC), 32'd0);
    drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 1'b1);
    tick();
    check("add2_sum", bus.oSum,    32'hACF1_3569);
    check("add2_c",   32'(bus.oC), 32'd0);
    drive(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    check("add3_sum", bus.oSum,    32'h0);
    check("add3_c",   32'(bus.oC), 32'd1);
    tick();

    // Three limbs: (2^96-1) + 1
    drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    check("l3_sum0",  bus.oSum,       32'h0);
    check("l3_c0",    32'(bus.oC),    32'd1);
    check("l3_last0", 32'(bus.oLast), 32'd0);
    drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check("l3_sum1",  bus.oSum,       32'h0);
    check("l3_c1",    32'(bus.oC),    32'd1);
    drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    check("l3_sum2",  bus.oSum,       32'h0);
    check("l3_c2",    32'(bus.oC),    32'd1);
    check("l3_last2", 32'(bus.oLast), 32'd1);
    check("l3_err",   32'(bus.oErr),  32'd0);
    tick();

    // Backpressure: hold iReady low for three cycles after first result
    drive(32'd1, 32'd10, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_sum0", bus.oSum, 32'd11);
    bus.iReady = 1'b0;
    drive(32'd2, 32'd20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", 32'(bus.oReady), 32'd0);
      check("bp_hold",  bus.oSum,        32'd11);
      check("bp_valid", 32'(bus.oValid), 32'd1);
    end
    bus.iReady = 1'b1;
    tick();
    check("bp_sum1",  bus.oSum,       32'd22);
    check("bp_last1", 32'(bus.oLast), 32'd0);
    drive(32'd3, 32'd30, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    check("bp_sum2",  bus.oSum,       32'd33);
    check("bp_last2", 32'(bus.oLast), 32'd1);
    check("bp_c2",    32'(bus.oC),    32'd0);
    tick();

    // iFirst while BUSY: restart with iC, stored carry discarded
    drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    check("rs_err_before", 32'(bus.oErr), 32'd0);
    drive(32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    check("rs_sum",  bus.oSum,       32'd3);
    check("rs_err",  32'(bus.oErr),  32'd1);
    check("rs_last", 32'(bus.oLast), 32'd1);
    drive(32'd4, 32'd4, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    check("sticky_sum", bus.oSum,      32'd8);
    check("sticky_err", 32'(bus.oErr), 32'd1);
    tick();

    // Reset between limb 2 and 3, then a non-first beat
    drive(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    check("ar_sum1", bus.oSum,    32'h0);
    check("ar_c1",   32'(bus.oC), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.oValid), 32'd0);
    check("ar_sum",   bus.oSum,        32'd0);
    check("ar_c",     32'(bus.oC),     32'd0);
    check("ar_last",  32'(bus.oLast),  32'd0);
    check("ar_err",   32'(bus.oErr),   32'd0);
    check("ar_ready", 32'(bus.oReady), 32'd1);
    tick();
    rst_n = 1'b1;
    drive(32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
    tick(); idle();
    check("post_sum",  bus.oSum,       32'd11);
    check("post_err",  32'(bus.oErr),  32'd1);
    check("post_last", 32'(bus.oLast), 32'd1);
    check("post_c",    32'(bus.oC),    32'd0);

`ifdef MP_LIMB_SUBTRACT_EN
    tick();
    bus.iSub = 1'b1;
    drive(32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    bus.iSub = 1'b0;
    check("sub_sum", bus.oSum,    32'hFFFF_FFFE);
    check("sub_c",   32'(bus.oC), 32'd0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mp_limb_adder.md
MP_LIMB_ADDER -- requirements
Module: mp_limb_adder

Interface
REQ-001 Parameter LIMB_WIDTH, default 32, operand limb width in bits; the block SHALL support only multiples of 4 (4..128).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 iValid  input  1  upstream limb beat valid.
REQ-005 oReady  output  1  block can accept a beat this cycle.
REQ-006 iA, iB  input  LIMB_WIDTH each  operand limbs, least-significant limb first.
REQ-007 iFirst  input  1  beat is the least-significant limb of an operand pair.
REQ-008 iLast  input  1  beat is the most-significant limb of an operand pair.
REQ-009 iC  input  1  carry-in; sampled only on an accepted first beat.
REQ-010 oValid  output  1  result limb valid.
REQ-011 iReady  input  1  downstream accepts result limb.
REQ-012 oSum  output  LIMB_WIDTH  sum limb.
REQ-013 oLast  output  1  result limb is most-significant of its operation.
REQ-014 oC  output  1  carry-out of the limb in oSum; meaningful to consumers on oLast.
REQ-015 oErr  output  1  sticky framing error flag.

Function
REQ-016 Accept occurs when iValid and oReady are both high; oReady SHALL equal (!oValid | iReady).
REQ-017 Per limb: form bitwise G=A&B, P=A^B, split into LIMB_WIDTH/4 groups of 4, resolve each group carry by 4-bit lookahead, chain groups LSB to MSB; sum = P ^ internal carries.
REQ-018 Limb carry-in SHALL be iC on a first beat, else the stored carry register.
REQ-019 Result SHALL appear on oSum/oC/oLast exactly one cycle after accept (registered output, latency 1); oValid held until taken.
REQ-020 Output register SHALL hold its value while oValid & !iReady (no data change under backpressure).
REQ-021 Back-to-back accepts every cycle SHALL be supported when iReady is held high (throughput 1 limb/cycle).
REQ-022 Framing FSM states: IDLE (expecting iFirst), BUSY (inside multi-limb operation).
REQ-023 IDLE: accept with iFirst&iLast -> IDLE; iFirst&!iLast -> BUSY; !iFirst -> treated as first (carry-in iC), oErr set, next state per iLast.
REQ-024 BUSY: accept with !iFirst&iLast -> IDLE; !iFirst&!iLast -> BUSY; iFirst -> operation restarts with iC, oErr set, next state per iLast.
REQ-025 Carry register SHALL load the limb carry-out on every accept and clear to 0 on accept with iLast.
REQ-026 No state change on cycles without accept.
REQ-027 oErr SHALL remain set until reset.
REQ-028 Limb carry-out of all-ones + 0 + carry-in 1 SHALL propagate across all groups in the same cycle (full-width carry wrap to oC, oSum=0).

Reset
REQ-029 Reset asserted mid-operation SHALL abort it immediately: FSM -> IDLE, carry register 0, oValid 0, oSum 0, oC 0, oLast 0, oErr 0.
REQ-030 oReady SHALL be 1 during and after reset (oValid=0).
REQ-031 First accept after reset release SHALL behave as an IDLE accept.

Configuration
REQ-032 Macro MP_LIMB_SUBTRACT_EN: when defined, add input iSub (1 bit, sampled on first beat, held for the operation); when iSub=1, iB is inverted per limb and first-limb carry-in is forced to 1 (A-B, oC=1 means no borrow).
REQ-033 Without MP_LIMB_SUBTRACT_EN, port iSub SHALL not exist and the block only adds.

Verification
REQ-034 LIMB_WIDTH=32, single beat first&last, A=0xFFFFFFFF, B=0x00000001, iC=0 -> next cycle oSum=0x00000000, oC=1, oLast=1.
REQ-035 Three-beat op A=2^96-1, B=1 limb-wise, iC=0, iReady=1 -> oSum 0,0,0 on consecutive cycles, oC=1 on third with oLast=1.
REQ-036 Hold iReady=0 for 3 cycles after first result -> oReady=0, oSum/oC stable, no beat lost; release -> remaining limbs in order.
REQ-037 Beat with iFirst while BUSY -> oErr=1, new op uses iC, prior carry discarded.
REQ-038 Assert rst_n=0 between limb 2 and 3 -> outputs zero asynchronously; next beat (no iFirst) -> oErr=1, carry-in iC.
REQ-039 With MP_LIMB_SUBTRACT_EN, iSub=1, A=5, B=7 single limb -> oSum=0xFFFFFFFE, oC=0.
